pe_array_sequencer: RTL

- Control FSM for an ARRAY_DIM x ARRAY_DIM weight-stationary systolic array of MAC processing elements.
- Per job, it loads weights row by row from the weight buffer, clears accumulators, then streams cfg_num_vec activation vectors.
- It drives the array-wide weight_load, clear_acc and accumulate controls and flags valid result rows at the array output.
- It sits between the job/command layer and the array plus its activation and weight buffers.

---
 rtl/pe_array_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_array_sequencer.sv
// Control FSM for a weight-stationary ARRAY_DIM x ARRAY_DIM MAC array: load weights, clear, stream, drain.
// Optional SEQ_WEIGHT_REUSE_EN adds keep_weights to skip reloading weights that are already resident.
module pe_array_sequencer #(
  parameter int ARRAY_DIM = 4,
  parameter int CNT_WIDTH = 8,
  parameter int LAT       = 2*ARRAY_DIM-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_num_vec,
`ifdef SEQ_WEIGHT_REUSE_EN
  input  logic                 keep_weights,
`endif
  output logic                 busy,
  output logic                 done,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [ARRAY_DIM-1:0] w_row_load,
  input  logic                 act_valid,
  output logic                 act_ready,
  output logic                 act_insert,
  output logic                 pe_clear_acc,
  output logic                 pe_accumulate,
  output logic                 result_valid
);

  localparam int RW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 zdone_q, zdone_d;
  logic [LAT-1:0]       vld_pipe_q;
`ifdef SEQ_WEIGHT_REUSE_EN
  logic                 wl_q, wl_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      row_q      <= '0;
      zdone_q    <= 1'b0;
      vld_pipe_q <= '0;
`ifdef SEQ_WEIGHT_REUSE_EN
      wl_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      zdone_q    <= zdone_d;
      // Tail of this shift register marks the array output row belonging to each insert.
      vld_pipe_q <= {vld_pipe_q[LAT-2:0], act_insert};
`ifdef SEQ_WEIGHT_REUSE_EN
      wl_q       <= wl_d;
`endif
    end
  end

  assign result_valid = vld_pipe_q[LAT-1];

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    acc_d         = acc_q;
    row_d         = row_q;
    zdone_d       = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = zdone_q;
    w_ready       = 1'b0;
    w_row_load    = '0;
    act_ready     = 1'b0;
    act_insert    = 1'b0;
    pe_clear_acc  = 1'b0;
    pe_accumulate = 1'b0;
`ifdef SEQ_WEIGHT_REUSE_EN
    wl_d          = wl_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_num_vec == '0) begin
            zdone_d = 1'b1;
          end else begin
            num_d   = cfg_num_vec;
            acc_d   = '0;
            row_d   = '0;
            state_d = S_LOAD_W;
`ifdef SEQ_WEIGHT_REUSE_EN
            if (keep_weights && wl_q) state_d = S_CLEAR;
`endif
          end
        end
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_row_load = ARRAY_DIM'(1) << row_q;
          if (row_q == RW'(ARRAY_DIM-1)) begin
            row_d   = '0;
            state_d = S_CLEAR;
`ifdef SEQ_WEIGHT_REUSE_EN
            wl_d    = 1'b1;
`endif
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        pe_clear_acc = 1'b1;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        // Bubbles keep accumulate high: a zero activation adds nothing.
        pe_accumulate = 1'b1;
        act_ready     = (acc_q < num_q);
        act_insert    = act_valid && act_ready;
        if (act_insert) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pe_accumulate = 1'b1;
        if (vld_pipe_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
